// File: rtl/routing_pkg.sv
// rtl/routing_pkg.sv - shared routing-table memory map and next-hop FSM encoding
//
// Purpose: one definition of the node-memory routing table layout used by the
// cost-learning stage and the next-hop selector, plus the selector state codes.
// Ports: none (package).
package routing_pkg;

  // Word addresses in shared node memory; per-neighbour tables use 2 words/entry.
  localparam logic [10:0] NEIGHBOR_ID_BASE   = 11'h048;
  localparam logic [10:0] BATTERY_BASE       = 11'h148;
  localparam logic [10:0] QVALUE_BASE        = 11'h1C8;
  localparam logic [10:0] SINKIDCOUNT_BASE   = 11'h68E;
  localparam logic [10:0] NEIGHBORCOUNT_ADDR = 11'h68A;

  // Selector FSM state encoding.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RCNT = 4'd1;
  localparam logic [3:0] S_RSC  = 4'd2;
  localparam logic [3:0] S_RBAT = 4'd3;
  localparam logic [3:0] S_RQ   = 4'd4;
  localparam logic [3:0] S_NEXT = 4'd5;
  localparam logic [3:0] S_EXPL = 4'd6;
  localparam logic [3:0] S_MOD  = 4'd7;
  localparam logic [3:0] S_RID  = 4'd8;
  localparam logic [3:0] S_RQF  = 4'd9;
  localparam logic [3:0] S_DONE = 4'd10;

  // Address of entry i in a 2-word-stride table; 11-bit wraparound is harmless for i < 64.
  function automatic logic [10:0] entry_addr(input logic [10:0] base, input logic [5:0] i);
    return base + {4'b0000, i, 1'b0};
  endfunction

endpackage

// File: rtl/select_next_hop_if.sv
// rtl/select_next_hop_if.sv - control, memory and result signals of the next-hop selector
//
// Purpose: bundles the selector's request inputs, its read-only memory port and
// its result outputs.
// Signals: en, epsilon, min_battery (request); address, data_in (memory);
//          next_hop_id, next_hop_q, hop_valid, explored, done (result).
// Modports: master = selector side, slave = environment side.
interface select_next_hop_if;
  import routing_pkg::*;

  logic        en;
  logic [15:0] epsilon;
  logic [15:0] min_battery;
  logic [15:0] data_in;
  logic [10:0] address;
  logic [15:0] next_hop_id;
  logic [15:0] next_hop_q;
  logic        hop_valid;
  logic        explored;
  logic        done;

  modport master (
    input  en, epsilon, min_battery, data_in,
    output address, next_hop_id, next_hop_q, hop_valid, explored, done
  );

  modport slave (
    output en, epsilon, min_battery, data_in,
    input  address, next_hop_id, next_hop_q, hop_valid, explored, done
  );

endinterface

// File: rtl/select_next_hop_lfsr16.sv
// rtl/select_next_hop_lfsr16.sv - free-running 16-bit Fibonacci LFSR for exploration
//
// Purpose: pseudo-random source, polynomial x^16+x^14+x^13+x^11+1, advancing
// every clock after reset.
// Ports: clock (in), rst (in, async active-high), q (out, 16-bit state).
// SEED must be non-zero or the register locks at zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        rst,
  output logic [15:0] q
);

  logic feedback;

  // Right-shifting form: taps 16,14,13,11 map to bits 0,2,3,5.
  assign feedback = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {feedback, q[15:1]};
    end
  end

endmodule

// File: rtl/select_next_hop.sv
// rtl/select_next_hop.sv - scans the neighbour table and picks the next hop
//
// Purpose: after a start request, walks the routing table in node memory and
// selects the minimum-qValue neighbour that has a known sink and enough
// battery; with probability set by epsilon it instead picks a random
// neighbour for exploration.
// Ports: clock (in), rst (in, async active-high),
//        bus (select_next_hop_if.master): en, epsilon, min_battery, data_in
//        in; address, next_hop_id, next_hop_q, hop_valid, explored, done out.
module select_next_hop
  import routing_pkg::*;
#(
  parameter int          MAX_NEIGHBORS = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  rst,
  select_next_hop_if.master     bus
);

  localparam logic [15:0] MAX_N16 = 16'(MAX_NEIGHBORS);
  localparam logic [6:0]  MAX_N7  = 7'(MAX_NEIGHBORS);

  logic [3:0]  state;
  logic [5:0]  idx;
  logic [5:0]  best_idx;
  logic [5:0]  sel;
  logic [6:0]  eidx;
  logic [6:0]  count;
  logic [15:0] best_q;
  logic        found;

  logic [10:0] address;
  logic [15:0] next_hop_id;
  logic [15:0] next_hop_q;
  logic        hop_valid;
  logic        explored;
  logic        done;

  logic [15:0] lfsr;
  logic [6:0]  cnt_clip;
  logic [5:0]  idx_inc;
  logic        last_entry;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .rst   (rst),
    .q     (lfsr)
  );

  // A corrupted count word can never push the scan past the table.
  assign cnt_clip   = (bus.data_in > MAX_N16) ? MAX_N7 : bus.data_in[6:0];
  assign idx_inc    = idx + 6'd1;
  assign last_entry = ({1'b0, idx} + 7'd1) == count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      best_idx    <= '0;
      sel         <= '0;
      eidx        <= '0;
      count       <= '0;
      best_q      <= '0;
      found       <= 1'b0;
      address     <= '0;
      next_hop_id <= '0;
      next_hop_q  <= '0;
      hop_valid   <= 1'b0;
      explored    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.en) begin
            idx       <= '0;
            found     <= 1'b0;
            best_idx  <= '0;
            hop_valid <= 1'b0;
            explored  <= 1'b0;
            done      <= 1'b0;
            best_q    <= 16'hFFFF;
            address   <= NEIGHBORCOUNT_ADDR;
            state     <= S_RCNT;
          end
        end
        S_RCNT: begin
          count <= cnt_clip;
          if (cnt_clip == 7'd0) begin
            state <= S_DONE;
          end else begin
            address <= entry_addr(SINKIDCOUNT_BASE, idx);
            state   <= S_RSC;
          end
        end
        S_RSC: begin
          // A neighbour with no route to any sink is useless as a next hop.
          if (bus.data_in == 16'd0) begin
            state <= S_NEXT;
          end else begin
            address <= entry_addr(BATTERY_BASE, idx);
            state   <= S_RBAT;
          end
        end
        S_RBAT: begin
          if (bus.data_in < bus.min_battery) begin
            state <= S_NEXT;
          end else begin
            address <= entry_addr(QVALUE_BASE, idx);
            state   <= S_RQ;
          end
        end
        S_RQ: begin
          // Strict compare: on a tie the earlier (lower-index) neighbour wins.
          if (bus.data_in < best_q) begin
            best_q   <= bus.data_in;
            best_idx <= idx;
            found    <= 1'b1;
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (last_entry) begin
            state <= S_EXPL;
          end else begin
            idx     <= idx_inc;
            address <= entry_addr(SINKIDCOUNT_BASE, idx_inc);
            state   <= S_RSC;
          end
        end
        S_EXPL: begin
          if (!found) begin
            state <= S_DONE;
          end else if (lfsr < bus.epsilon) begin
            eidx  <= {1'b0, lfsr[5:0]};
            state <= S_MOD;
          end else begin
            sel     <= best_idx;
            address <= entry_addr(NEIGHBOR_ID_BASE, best_idx);
            state   <= S_RID;
          end
        end
        S_MOD: begin
          // Iterative reduction of the random index modulo count; no divider.
          if (eidx >= count) begin
            eidx <= eidx - count;
          end else begin
            sel      <= eidx[5:0];
            explored <= 1'b1;
            address  <= entry_addr(NEIGHBOR_ID_BASE, eidx[5:0]);
            state    <= S_RID;
          end
        end
        S_RID: begin
          next_hop_id <= bus.data_in;
          address     <= entry_addr(QVALUE_BASE, sel);
          state       <= S_RQF;
        end
        S_RQF: begin
          next_hop_q <= bus.data_in;
          hop_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.address     = address;
  assign bus.next_hop_id = next_hop_id;
  assign bus.next_hop_q  = next_hop_q;
  assign bus.hop_valid   = hop_valid;
  assign bus.explored    = explored;
  assign bus.done        = done;

endmodule

// File: tb/tb_select_next_hop.sv
// tb/tb_select_next_hop.sv - directed self-checking bench for select_next_hop
module tb_select_next_hop;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  select_next_hop_if bus();

  select_next_hop #(.MAX_NEIGHBORS(64), .LFSR_SEED(16'hACE1)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];
  assign bus.data_in = mem[bus.address];

  // Clock edges since reset release; the LFSR value equals seed stepped this many times.
  int edges = 0;
  always @(posedge clock or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  int checks = 0;
  int passes = 0;

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
  endtask

  task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] bat,
                           input logic [15:0] q, input logic [15:0] sc);
    mem[16'h048 + 2 * i] = id;
    mem[16'h148 + 2 * i] = bat;
    mem[16'h1C8 + 2 * i] = q;
    mem[16'h68E + 2 * i] = sc;
  endtask

  task automatic load_base_table();
    clear_mem();
    mem[16'h68A] = 16'd3;
    set_entry(0, 16'd5,  16'd100, 16'd40, 16'd1);
    set_entry(1, 16'd9,  16'd100, 16'd25, 16'd1);
    set_entry(2, 16'd12, 16'd100, 16'd30, 16'd1);
  endtask

  // Pulses en so that it is sampled at edge en_edge (or the next edge when 0),
  // then waits for done, counting edges from the en edge (inclusive).
  task automatic run_select(input int en_edge, output int cycles, output bit addr_cnt_only);
    addr_cnt_only = 1'b1;
    @(negedge clock);
    while (edges < en_edge - 1) @(negedge clock);
    bus.en = 1'b1;
    @(posedge clock);
    #1;
    bus.en = 1'b0;
    cycles = 1;
    if (bus.address !== 11'h68A) addr_cnt_only = 1'b0;
    while (bus.done !== 1'b1 && cycles < 300) begin
      @(posedge clock);
      #1;
      cycles++;
      if (bus.address !== 11'h68A) addr_cnt_only = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.epsilon = 16'd0;
    bus.min_battery = 16'd50;
    clear_mem();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.address !== 11'd0) $display("FAIL reset_address: got %0h expected 0", bus.address); else passes++;
    checks++; if (bus.next_hop_id !== 16'd0) $display("FAIL reset_id: got %0h expected 0", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd0) $display("FAIL reset_q: got %0h expected 0", bus.next_hop_q); else passes++;
    checks++; if (bus.hop_valid !== 1'b0) $display("FAIL reset_hop_valid: got %b expected 0", bus.hop_valid); else passes++;
    checks++; if (bus.explored !== 1'b0) $display("FAIL reset_explored: got %b expected 0", bus.explored); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passes++;
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.done !== 1'b0) $display("FAIL idle_no_en_done: got %b expected 0", bus.done); else passes++;
  endtask

  task automatic test_empty_table();
    int cyc;
    bit only;
    clear_mem();
    run_select(0, cyc, only);
    checks++; if (cyc !== 3) $display("FAIL empty_latency: got %0d expected 3", cyc); else passes++;
    checks++; if (bus.done !== 1'b1) $display("FAIL empty_done: got %b expected 1", bus.done); else passes++;
    checks++; if (bus.hop_valid !== 1'b0) $display("FAIL empty_hop_valid: got %b expected 0", bus.hop_valid); else passes++;
    checks++; if (only !== 1'b1) $display("FAIL empty_address: got other addresses expected only 68a"); else passes++;
  endtask

  task automatic test_greedy();
    int cyc;
    bit only;
    load_base_table();
    run_select(0, cyc, only);
    checks++; if (cyc !== 18) $display("FAIL greedy_latency: got %0d expected 18", cyc); else passes++;
    checks++; if (bus.next_hop_id !== 16'd9) $display("FAIL greedy_id: got %0d expected 9", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd25) $display("FAIL greedy_q: got %0d expected 25", bus.next_hop_q); else passes++;
    checks++; if (bus.hop_valid !== 1'b1) $display("FAIL greedy_hop_valid: got %b expected 1", bus.hop_valid); else passes++;
    checks++; if (bus.explored !== 1'b0) $display("FAIL greedy_explored: got %b expected 0", bus.explored); else passes++;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (bus.done !== 1'b1) $display("FAIL done_held: got %b expected 1", bus.done); else passes++;
  endtask

  task automatic test_filters();
    int cyc;
    bit only;
    load_base_table();
    mem[16'h148 + 2] = 16'd20;
    run_select(0, cyc, only);
    checks++; if (bus.next_hop_id !== 16'd12) $display("FAIL battery_id: got %0d expected 12", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd30) $display("FAIL battery_q: got %0d expected 30", bus.next_hop_q); else passes++;
    mem[16'h68E + 4] = 16'd0;
    run_select(0, cyc, only);
    checks++; if (bus.next_hop_id !== 16'd5) $display("FAIL sink_id: got %0d expected 5", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd40) $display("FAIL sink_q: got %0d expected 40", bus.next_hop_q); else passes++;
    checks++; if (bus.hop_valid !== 1'b1) $display("FAIL sink_hop_valid: got %b expected 1", bus.hop_valid); else passes++;
  endtask

  task automatic test_tie();
    int cyc;
    bit only;
    load_base_table();
    mem[16'h1C8] = 16'd25;
    run_select(0, cyc, only);
    checks++; if (bus.next_hop_id !== 16'd5) $display("FAIL tie_id: got %0d expected 5", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd25) $display("FAIL tie_q: got %0d expected 25", bus.next_hop_q); else passes++;
  endtask

  task automatic test_explore();
    int cyc;
    bit only;
    int k0;
    logic [15:0] v;
    load_base_table();
    bus.epsilon = 16'hFFFF;
    // Choose the en edge so the LFSR seen in EXPL (13 edges later) has low bits 7.
    k0 = -1;
    for (int k = edges + 3; k < edges + 3000; k++) begin
      v = lfsr_after(k + 13);
      if (k0 < 0 && v[5:0] == 6'd7 && v != 16'hFFFF) k0 = k;
    end
    checks++;
    if (k0 < 0) begin
      $display("FAIL explore_setup: got no usable edge expected one");
    end else begin
      passes++;
      run_select(k0, cyc, only);
      checks++; if (cyc !== 21) $display("FAIL explore_latency: got %0d expected 21", cyc); else passes++;
      checks++; if (bus.next_hop_id !== 16'd9) $display("FAIL explore_id: got %0d expected 9", bus.next_hop_id); else passes++;
      checks++; if (bus.next_hop_q !== 16'd25) $display("FAIL explore_q: got %0d expected 25", bus.next_hop_q); else passes++;
      checks++; if (bus.explored !== 1'b1) $display("FAIL explore_flag: got %b expected 1", bus.explored); else passes++;
      checks++; if (bus.hop_valid !== 1'b1) $display("FAIL explore_hop_valid: got %b expected 1", bus.hop_valid); else passes++;
    end
    bus.epsilon = 16'd0;
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    bit only;
    load_base_table();
    @(negedge clock);
    bus.en = 1'b1;
    @(posedge clock);
    #1;
    bus.en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.address !== 11'd0) $display("FAIL midrst_address: got %0h expected 0", bus.address); else passes++;
    checks++; if (bus.next_hop_id !== 16'd0) $display("FAIL midrst_id: got %0h expected 0", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd0) $display("FAIL midrst_q: got %0h expected 0", bus.next_hop_q); else passes++;
    checks++; if (bus.explored !== 1'b0) $display("FAIL midrst_explored: got %b expected 0", bus.explored); else passes++;
    @(negedge clock);
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.done !== 1'b0) $display("FAIL midrst_no_result: got %b expected 0", bus.done); else passes++;
    run_select(0, cyc, only);
    checks++; if (cyc !== 18) $display("FAIL after_rst_latency: got %0d expected 18", cyc); else passes++;
    checks++; if (bus.next_hop_id !== 16'd9) $display("FAIL after_rst_id: got %0d expected 9", bus.next_hop_id); else passes++;
    checks++; if (bus.next_hop_q !== 16'd25) $display("FAIL after_rst_q: got %0d expected 25", bus.next_hop_q); else passes++;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.epsilon = 16'd0;
    bus.min_battery = 16'd50;
    test_reset();
    test_empty_table();
    test_greedy();
    test_filters();
    test_tie();
    test_explore();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
